ballot_controller: RTL

BALLOT_CONTROLLER -- requirements
Module: ballot_controller

---
 rtl/ballot_if.sv | 37 +++
 rtl/ballot_controller.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ballot_if.sv
// Ballot controller front-panel bundle: officer/candidate inputs, status outputs.
// multi_press exists only when MULTI_REJECT_EN is defined.
interface ballot_if;
  logic       mode;
  logic       ballot_enable;
  logic [3:0] cand_btn;
  logic       armed;
  logic       valid_vote_casted;
  logic [3:0] vote_onehot;
  logic       ballot_timeout;
  logic       busy;
`ifdef MULTI_REJECT_EN
  logic       multi_press;

  modport master (
    output mode, ballot_enable, cand_btn,
    input  armed, valid_vote_casted, vote_onehot,
    input  ballot_timeout, busy, multi_press
  );
  modport slave (
    input  mode, ballot_enable, cand_btn,
    output armed, valid_vote_casted, vote_onehot,
    output ballot_timeout, busy, multi_press
  );
`else
  modport master (
    output mode, ballot_enable, cand_btn,
    input  armed, valid_vote_casted, vote_onehot,
    input  ballot_timeout, busy
  );
  modport slave (
    input  mode, ballot_enable, cand_btn,
    output armed, valid_vote_casted, vote_onehot,
    output ballot_timeout, busy
  );
`endif
endinterface

// File: rtl/ballot_controller.sv
// Voting-machine ballot FSM: arm, commit one vote, lockout, saturating tallies.
// MULTI_REJECT_EN: simultaneous candidate edges are rejected instead of prioritised.
module ballot_controller #(
  parameter int CNT_W    = 4,
  parameter int LOCK_CYC = 125000000,
  parameter int ARM_TMO  = 250000000
) (
  input  logic             clock,
  input  logic             reset,
  ballot_if.slave          bus,
  output logic [CNT_W-1:0] tally1,
  output logic [CNT_W-1:0] tally2,
  output logic [CNT_W-1:0] tally3,
  output logic [CNT_W-1:0] tally4
);
  localparam int AW = $clog2(ARM_TMO + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TMO - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] SAT = '1;

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT, LOCKOUT} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    arm_q, arm_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic [3:0]       sel_q, sel_d;
  logic             tmo_q, tmo_d;
  logic             en_lvl_q, en_lvl_d;
  logic             en_edge_q, en_edge_d;
  logic [3:0]       cand_lvl_q, cand_lvl_d;
  logic [3:0]       cand_edge_q, cand_edge_d;
  logic [CNT_W-1:0] tally_q [4];
  logic [CNT_W-1:0] tally_d [4];
  logic [3:0]       pick;
  logic             reject;

  // Lowest set bit: candidate1 has priority.
  assign pick = cand_edge_q & (~cand_edge_q + 4'd1);

`ifdef MULTI_REJECT_EN
  assign reject = |(cand_edge_q & (cand_edge_q - 4'd1));
  assign bus.multi_press = (state_q == ARMED) && !bus.mode && reject;
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    arm_d       = arm_q;
    lock_d      = lock_q;
    sel_d       = sel_q;
    tmo_d       = 1'b0;
    tally_d     = tally_q;
    en_lvl_d    = bus.ballot_enable;
    en_edge_d   = bus.ballot_enable & ~en_lvl_q;
    cand_lvl_d  = bus.cand_btn;
    cand_edge_d = bus.cand_btn & ~cand_lvl_q;
    unique case (state_q)
      IDLE: begin
        if (en_edge_q && !bus.mode) begin
          state_d = ARMED;
          arm_d   = '0;
        end
      end
      ARMED: begin
        arm_d = arm_q + AW'(1);
        if (bus.mode) begin
          state_d = IDLE;
        end else if ((|cand_edge_q) && !reject) begin
          state_d = COMMIT;
          sel_d   = pick;
        end else if (arm_q == ARM_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      COMMIT: begin
        for (int i = 0; i < 4; i++) begin
          if (sel_q[i] && (tally_q[i] != SAT)) begin
            tally_d[i] = tally_q[i] + CNT_W'(1);
          end
        end
        state_d = LOCKOUT;
        lock_d  = '0;
      end
      LOCKOUT: begin
        lock_d = lock_q + LW'(1);
        if (lock_q == LOCK_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      arm_q       <= '0;
      lock_q      <= '0;
      sel_q       <= '0;
      tmo_q       <= 1'b0;
      en_lvl_q    <= 1'b0;
      en_edge_q   <= 1'b0;
      cand_lvl_q  <= '0;
      cand_edge_q <= '0;
      for (int i = 0; i < 4; i++) tally_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      lock_q      <= lock_d;
      sel_q       <= sel_d;
      tmo_q       <= tmo_d;
      en_lvl_q    <= en_lvl_d;
      en_edge_q   <= en_edge_d;
      cand_lvl_q  <= cand_lvl_d;
      cand_edge_q <= cand_edge_d;
      for (int i = 0; i < 4; i++) tally_q[i] <= tally_d[i];
    end
  end

  assign bus.armed             = (state_q == ARMED);
  assign bus.busy              = (state_q == LOCKOUT);
  assign bus.valid_vote_casted = (state_q == COMMIT);
  assign bus.vote_onehot       = (state_q == COMMIT) ? sel_q : 4'b0;
  assign bus.ballot_timeout    = tmo_q;

  assign tally1 = tally_q[0];
  assign tally2 = tally_q[1];
  assign tally3 = tally_q[2];
  assign tally4 = tally_q[3];
endmodule
